instr_fetch_buffer: RTL and testbench

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

---
 rtl/instr_fetch_buffer.sv | 88 ++++++++
 tb/tb_instr_fetch_buffer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer.sv
// Single-line instruction fetch buffer: one 4-word line in front of a slow instruction memory.
// Optional macro IFB_NOP_ON_MISS_EN drives a NOP on INSTRUCTION while the CPU is stalled.
module instr_fetch_buffer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PC,
  output logic [18:0] INSTRUCTION,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic [29:0] MEM_ADDR,
  input  logic [75:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  localparam int unsigned WORD_W = 19;
  localparam int unsigned WORDS  = 4;
  localparam int unsigned TAG_W  = 30;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                        state;
  state_t                        state_nxt;
  logic                          line_valid;
  logic [TAG_W-1:0]              line_tag;
  logic [WORDS-1:0][WORD_W-1:0]  line_data;
  logic [TAG_W-1:0]              req_addr;
  logic [WORD_W-1:0]             instr_hold;
  logic                          hit_c;
  logic                          fill_c;
  logic [WORD_W-1:0]             hit_word_c;

  assign hit_c      = (state == IDLE) && line_valid && (line_tag == PC[31:2]);
  assign hit_word_c = line_data[PC[1:0]];

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; fill fires only while a fetch is actually outstanding
  always_comb begin
    state_nxt = state;
    fill_c    = 1'b0;
    case (state)
      IDLE:  if (!hit_c) state_nxt = FETCH;
      FETCH: if (!MEM_BUSYWAIT) begin
        state_nxt = IDLE;
        fill_c    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line storage and request address; reset beats a same-edge fill
  always_ff @(posedge CLK) begin
    if (RESET) begin
      line_valid <= 1'b0;
      line_tag   <= '0;
      line_data  <= '0;
      req_addr   <= '0;
    end else begin
      if (state == IDLE && !hit_c) req_addr <= PC[31:2];
      if (fill_c) begin
        line_data  <= MEM_READDATA;
        line_tag   <= req_addr;
        line_valid <= 1'b1;
      end
    end
  end

  // Last instruction handed out on a hit, replayed while stalled
  always_ff @(posedge CLK) begin
    if (RESET)      instr_hold <= '0;
    else if (hit_c) instr_hold <= hit_word_c;
  end

  assign BUSYWAIT = !hit_c;
  assign MEM_READ = (state == FETCH);
  assign MEM_ADDR = req_addr;

`ifdef IFB_NOP_ON_MISS_EN
  assign INSTRUCTION = hit_c ? hit_word_c : WORD_W'(0);
`else
  assign INSTRUCTION = hit_c ? hit_word_c : instr_hold;
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Scoreboard bench for instr_fetch_buffer: driver queues per-cycle expectations, monitor compares.
module tb_instr_fetch_buffer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] PC = 32'h0;
  logic [18:0] INSTRUCTION;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic [29:0] MEM_ADDR;
  logic [75:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  typedef struct {
    logic        busy;
    logic        mread;
    logic [29:0] maddr;
    logic [18:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          lat = 3;
  int          mem_cnt = 0;
  logic [18:0] last = '0;

  instr_fetch_buffer dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_ADDR(MEM_ADDR), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [18:0] w(input logic [31:0] p);
    return 19'(p * 32'd3 + 32'h155);
  endfunction

  function automatic logic [18:0] stall(input logic [18:0] prev);
`ifdef IFB_NOP_ON_MISS_EN
    return 19'(prev & 19'h0);
`else
    return prev;
`endif
  endfunction

  // Memory: completes in the lat-th FETCH cycle; outside a fetch it idles with junk data
  initial begin
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = '1;
    forever begin
      @(posedge CLK);
      #1;
      if (MEM_READ === 1'b1) begin
        for (int i = 0; i < 4; i++) MEM_READDATA[19*i +: 19] = w({MEM_ADDR, 2'(i)});
        MEM_BUSYWAIT = (mem_cnt != lat - 1);
        mem_cnt++;
      end else begin
        mem_cnt      = 0;
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = '1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: compares the cycle's outputs against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("busywait", 32'(BUSYWAIT), 32'(e.busy));
        check("mem_read", 32'(MEM_READ), 32'(e.mread));
        if (e.mread) check("mem_addr", 32'(MEM_ADDR), 32'(e.maddr));
        check("instruction", 32'(INSTRUCTION), 32'(e.instr));
      end
    end
  end

  task automatic push(input logic busy, input logic mread, input logic [29:0] maddr,
                      input logic [18:0] instr);
    exp_t e;
    e.busy = busy; e.mread = mread; e.maddr = maddr; e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [31:0] pc, input logic rst, input logic busy,
                     input logic mread, input logic [29:0] maddr, input logic [18:0] instr);
    @(posedge CLK);
    #1;
    PC = pc;
    RESET = rst;
    push(busy, mread, maddr, instr);
  endtask

  task automatic hit(input logic [31:0] pc);
    cyc(pc, 1'b0, 1'b0, 1'b0, 30'h0, w(pc));
    last = w(pc);
  endtask

  // One IDLE miss cycle then l FETCH cycles, BUSYWAIT high for l+1 cycles
  task automatic miss(input logic [31:0] pc, input int l);
    lat = l;
    cyc(pc, 1'b0, 1'b1, 1'b0, 30'h0, stall(last));
    repeat (l) cyc(pc, 1'b0, 1'b1, 1'b1, pc[31:2], stall(last));
  endtask

  initial begin
    // Cold miss after one reset edge, latency 3
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    PC = 32'h10;
    push(1'b1, 1'b0, 30'h0, 19'h0);
    repeat (3) cyc(32'h10, 1'b0, 1'b1, 1'b1, 30'h4, 19'h0);
    // Sequential hits through word 3
    hit(32'h10); hit(32'h11); hit(32'h12); hit(32'h13);
    // Block crossing replaces the line; returning to block 4 misses again (latency 1)
    miss(32'h14, 3); hit(32'h14);
    miss(32'h10, 1); hit(32'h10);
    // PC change mid-fetch: fetch for block 4 completes, then block 8 is fetched
    miss(32'h30, 2); hit(32'h30);
    lat = 3;
    cyc(32'h10, 1'b0, 1'b1, 1'b0, 30'h0, stall(last));
    cyc(32'h10, 1'b0, 1'b1, 1'b1, 30'h4, stall(last));
    cyc(32'h20, 1'b0, 1'b1, 1'b1, 30'h4, stall(last));
    cyc(32'h20, 1'b0, 1'b1, 1'b1, 30'h4, stall(last));
    miss(32'h20, 3); hit(32'h20); hit(32'h23);
    // Address wrap is an ordinary miss
    miss(32'hFFFF_FFFF, 2); hit(32'hFFFF_FFFF);
    miss(32'h0, 2); hit(32'h0); hit(32'h3);
    // Reset on the completing edge of a fetch aborts it; line stays invalid
    lat = 2;
    cyc(32'h10, 1'b0, 1'b1, 1'b0, 30'h0, stall(last));
    cyc(32'h10, 1'b0, 1'b1, 1'b1, 30'h4, stall(last));
    cyc(32'h10, 1'b1, 1'b1, 1'b1, 30'h4, stall(last));
    last = '0;
    cyc(32'h10, 1'b1, 1'b1, 1'b0, 30'h0, 19'h0);
    miss(32'h10, 3); hit(32'h10); hit(32'h12);
    @(posedge CLK);
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
